// File: rtl/neotang_clk_pkg.sv
// Shared constants and types for the core-clock enable generator.
// Increments are 2^32 * f_out / 96 MHz.
package neotang_clk_pkg;

  localparam int unsigned CORE_CLK_HZ = 96_000_000;

  localparam logic [31:0] INC_AUDIO_24M576 = 32'h4189374C;
  localparam logic [31:0] INC_PIX_6M       = 32'h10000000;
  localparam logic [31:0] INC_CPU_12M      = 32'h20000000;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    FILTER,
    RUN
  } lock_state_t;

endpackage

// File: rtl/clken_lock_filter.sv
// Synchronises the PLL lock indicator and requires LOCK_FILTER consecutive
// synchronised-high cycles before declaring the generator ready.
module clken_lock_filter
  import neotang_clk_pkg::*;
#(
  parameter int LOCK_FILTER = 1024
) (
  input  logic clkin,
  input  logic rst,
  input  logic pll_lock,
  output logic ready
);

  localparam int CNT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_FILTER - 1);

  logic             sync_p0;
  logic             lock_s;
  lock_state_t      state;
  lock_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clkin) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      lock_s  <= 1'b0;
      state   <= WAIT_LOCK;
      cnt     <= '0;
      ready   <= 1'b0;
    end else begin
      sync_p0 <= pll_lock;
      lock_s  <= sync_p0;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready   <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = FILTER;
      end
      FILTER: begin
        if (cnt == CNT_LAST) state_nxt = RUN;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      RUN: ;
      default: state_nxt = WAIT_LOCK;
    endcase
    // Any loss of the synchronised lock restarts qualification from scratch.
    if (!lock_s) begin
      state_nxt = WAIT_LOCK;
      cnt_nxt   = '0;
    end
  end

endmodule

// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator: one phase-accumulator NCO
// per channel, gated by a qualified PLL lock and a run enable.
module clken_gen
  import neotang_clk_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int ACC_W       = 32,
  parameter int LOCK_FILTER = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] INC_DEFAULT =
    {INC_CPU_12M, INC_PIX_6M, INC_AUDIO_24M576},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              pll_lock,
  input  logic              enable,
  input  logic              sync_pulse,
  input  logic              inc_wr,
  input  logic [CH_W-1:0]   inc_ch,
  input  logic [ACC_W-1:0]  inc_data,
  output logic [NUM_CH-1:0] ce,
  output logic              ready
);

  logic acc_run;

  function automatic logic [ACC_W:0] nco_add(input logic [ACC_W-1:0] acc,
                                             input logic [ACC_W-1:0] inc);
    return {1'b0, acc} + {1'b0, inc};
  endfunction

  clken_lock_filter #(
    .LOCK_FILTER(LOCK_FILTER)
  ) u_lock (
    .clkin   (clkin),
    .rst     (rst),
    .pll_lock(pll_lock),
    .ready   (ready)
  );

  assign acc_run = ready & enable;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] acc_p0;
    logic [ACC_W:0]   sum;
    logic             ce_p1;

    assign sum   = nco_add(acc_p0, inc_q);
    assign ce[g] = ce_p1;

    // Out-of-range channel indices never match any g, so they are ignored.
    always_ff @(posedge clkin) begin
      if (rst)                                 inc_q <= INC_DEFAULT[g*ACC_W +: ACC_W];
      else if (inc_wr && (int'(inc_ch) == g))  inc_q <= inc_data;
    end

    // --- stage p0 -> p1: accumulate, carry out becomes the enable pulse
    always_ff @(posedge clkin) begin
      if (rst || !acc_run || sync_pulse) begin
        acc_p0 <= '0;
        ce_p1  <= 1'b0;
      end else begin
        acc_p0 <= sum[ACC_W-1:0];
        ce_p1  <= sum[ACC_W];
      end
    end
  end

endmodule

// File: tb/tb_clken_gen.sv
// Randomised self-checking bench for clken_gen against a phase/run-length model.
module tb_clken_gen;

  localparam int LF = 16;
  localparam logic [31:0] D0 = 32'h4189374C;
  localparam logic [31:0] D1 = 32'h10000000;
  localparam logic [31:0] D2 = 32'h20000000;

  logic        clkin = 1'b0;
  logic        rst, pll_lock, enable, sync_pulse, inc_wr;
  logic [1:0]  inc_ch;
  logic [31:0] inc_data;
  logic [2:0]  ce;
  logic        ready;

  int cmp  = 0;
  int errs = 0;

  always #5 clkin = ~clkin;

  clken_gen #(
    .NUM_CH(3), .ACC_W(32), .LOCK_FILTER(LF), .INC_DEFAULT({D2, D1, D0})
  ) dut (
    .clkin(clkin), .rst(rst), .pll_lock(pll_lock), .enable(enable),
    .sync_pulse(sync_pulse), .inc_wr(inc_wr), .inc_ch(inc_ch),
    .inc_data(inc_data), .ce(ce), .ready(ready)
  );

  // Reference model: ready is high once pll_lock, seen two edges earlier, has
  // been high for LF+1 consecutive samples. Each channel keeps an unbounded
  // phase total; a pulse follows every add that crosses a multiple of 2^32.
  int              m_run, m_run_d1;
  logic            m_ready;
  logic [31:0]     m_inc [3];
  longint unsigned m_ph  [3];
  logic [2:0]      m_ce;

  always @(posedge clkin) begin
    if (rst) begin
      m_run    <= 0;
      m_run_d1 <= 0;
      m_ready  <= 1'b0;
      m_ce     <= 3'b000;
      m_inc[0] <= D0;
      m_inc[1] <= D1;
      m_inc[2] <= D2;
      for (int i = 0; i < 3; i++) m_ph[i] <= 64'd0;
    end else begin
      m_run    <= pll_lock ? ((m_run < 100000) ? m_run + 1 : m_run) : 0;
      m_run_d1 <= m_run;
      m_ready  <= (m_run_d1 >= LF + 1);
      for (int i = 0; i < 3; i++) begin
        if (!(m_ready && enable) || sync_pulse) begin
          m_ph[i] <= 64'd0;
          m_ce[i] <= 1'b0;
        end else begin
          m_ph[i] <= m_ph[i] + 64'(m_inc[i]);
          m_ce[i] <= ((m_ph[i] + 64'(m_inc[i])) >> 32) != (m_ph[i] >> 32);
        end
      end
      if (inc_wr && inc_ch < 2'd3) m_inc[inc_ch] <= inc_data;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clkin);
    cmp++;
    if (ce !== 3'b000) begin errs++; $display("FAIL reset_ce: got %b want 000", ce); end
    cmp++;
    if (ready !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b want 0", ready); end
    rst = 1'b0;
  endtask

  task automatic test_lock_qualify();
    int rise_at;
    rise_at = -1;
    enable = 1'b1;
    pll_lock = 1'b0;
    repeat (4) @(negedge clkin);
    pll_lock = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clkin);
      cmp++;
      if (ready !== m_ready || ce !== m_ce) begin
        errs++;
        $display("FAIL lock_qualify cyc %0d: ce=%b ready=%b want ce=%b ready=%b", i, ce, ready, m_ce, m_ready);
      end
      if (ready !== 1'b1) begin
        cmp++;
        if (ce !== 3'b000) begin errs++; $display("FAIL ce_before_ready: got %b want 000", ce); end
      end else if (rise_at < 0) rise_at = i;
    end
    cmp++;
    if (rise_at != LF + 3) begin errs++; $display("FAIL lock_latency: got %0d want %0d", rise_at, LF + 3); end
    enable = 1'b0;
  endtask

  task automatic test_lock_glitch();
    int rise_at;
    rise_at = -1;
    pll_lock = 1'b0;
    repeat (4) @(negedge clkin);
    pll_lock = 1'b1;
    repeat (10) @(negedge clkin);
    pll_lock = 1'b0;
    @(negedge clkin);
    pll_lock = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clkin);
      cmp++;
      if (ready !== m_ready || ce !== m_ce) begin
        errs++;
        $display("FAIL lock_glitch cyc %0d: ce=%b ready=%b want ce=%b ready=%b", i, ce, ready, m_ce, m_ready);
      end
      if (ready === 1'b1 && rise_at < 0) rise_at = i;
    end
    cmp++;
    if (rise_at != LF + 3) begin errs++; $display("FAIL relock_latency: got %0d want %0d", rise_at, LF + 3); end
  endtask

  task automatic test_exact_rate();
    int first, npulse, prev, badper;
    first = -1; npulse = 0; prev = 0; badper = 0;
    enable = 1'b0;
    inc_wr = 1'b1; inc_ch = 2'd0; inc_data = 32'h40000000;
    @(negedge clkin);
    inc_wr = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clkin);
      cmp++;
      if (ce !== m_ce) begin errs++; $display("FAIL exact_rate cyc %0d: ce=%b want %b", i, ce, m_ce); end
      if (ce[0] === 1'b1) begin
        if (first < 0) first = i;
        else if (i - prev != 4) badper++;
        prev = i;
        npulse++;
      end
    end
    cmp++;
    if (first != 4) begin errs++; $display("FAIL first_pulse: got %0d want 4", first); end
    cmp++;
    if (npulse != 250) begin errs++; $display("FAIL pulse_count_1000: got %0d want 250", npulse); end
    cmp++;
    if (badper != 0) begin errs++; $display("FAIL period4: got %0d bad periods want 0", badper); end
  endtask

  task automatic test_runtime_write();
    int n1, n0;
    n1 = 0; n0 = 0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clkin);
      cmp++;
      if (ce !== m_ce) begin errs++; $display("FAIL pre_write cyc %0d: ce=%b want %b", i, ce, m_ce); end
    end
    inc_wr = 1'b1; inc_ch = 2'd1; inc_data = 32'h80000000;
    @(negedge clkin);
    inc_wr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clkin);
      cmp++;
      if (ce !== m_ce) begin errs++; $display("FAIL post_write cyc %0d: ce=%b want %b", i, ce, m_ce); end
      if (i >= 20 && ce[1] === 1'b1) n1++;
    end
    cmp++;
    if (n1 != 10) begin errs++; $display("FAIL ch1_period2: got %0d pulses in 20 want 10", n1); end
    inc_wr = 1'b1; inc_ch = 2'd3; inc_data = 32'h00000000;
    @(negedge clkin);
    inc_wr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clkin);
      cmp++;
      if (ce !== m_ce) begin errs++; $display("FAIL bad_ch_write cyc %0d: ce=%b want %b", i, ce, m_ce); end
      if (ce[0] === 1'b1) n0++;
    end
    cmp++;
    if (n0 != 10) begin errs++; $display("FAIL ch0_after_bad_write: got %0d pulses in 40 want 10", n0); end
  endtask

  task automatic test_sync();
    int f0, f1;
    f0 = -1; f1 = -1;
    inc_wr = 1'b1; inc_ch = 2'd1; inc_data = 32'h20000000;
    @(negedge clkin);
    inc_wr = 1'b0;
    repeat (13) @(negedge clkin);
    sync_pulse = 1'b1;
    inc_wr = 1'b1; inc_ch = 2'd2; inc_data = 32'h30000000;
    @(negedge clkin);
    sync_pulse = 1'b0;
    inc_wr = 1'b0;
    cmp++;
    if (ce !== 3'b000) begin errs++; $display("FAIL sync_clear: got %b want 000", ce); end
    for (int j = 1; j <= 16; j++) begin
      @(negedge clkin);
      cmp++;
      if (ce !== m_ce) begin errs++; $display("FAIL post_sync cyc %0d: ce=%b want %b", j, ce, m_ce); end
      if (ce[0] === 1'b1 && f0 < 0) f0 = j;
      if (ce[1] === 1'b1 && f1 < 0) f1 = j;
    end
    cmp++;
    if (f0 != 4) begin errs++; $display("FAIL sync_ch0_first: got %0d want 4", f0); end
    cmp++;
    if (f1 != 8) begin errs++; $display("FAIL sync_ch1_first: got %0d want 8", f1); end
  endtask

  task automatic test_reset_mid_run();
    localparam int N = 12000;
    int              cnt [3];
    longint unsigned want [3];
    int              waited;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    want[0] = (longint'(N) * D0) >> 32;
    want[1] = (longint'(N) * D1) >> 32;
    want[2] = (longint'(N) * D2) >> 32;
    repeat (5) @(negedge clkin);
    rst = 1'b1;
    @(negedge clkin);
    rst = 1'b0;
    cmp++;
    if (ce !== 3'b000) begin errs++; $display("FAIL midrst_ce: got %b want 000", ce); end
    cmp++;
    if (ready !== 1'b0) begin errs++; $display("FAIL midrst_ready: got %b want 0", ready); end
    waited = 0;
    while (ready !== 1'b1 && waited < 40) begin
      @(negedge clkin);
      waited++;
    end
    cmp++;
    if (ready !== 1'b1) begin errs++; $display("FAIL relock_timeout: ready=%b want 1", ready); end
    for (int i = 1; i <= N; i++) begin
      @(negedge clkin);
      cmp++;
      if (ce !== m_ce) begin errs++; $display("FAIL default_rate cyc %0d: ce=%b want %b", i, ce, m_ce); end
      for (int c = 0; c < 3; c++) if (ce[c] === 1'b1) cnt[c]++;
    end
    for (int c = 0; c < 3; c++) begin
      cmp++;
      if (longint'(cnt[c]) != want[c]) begin
        errs++;
        $display("FAIL default_count ch%0d: got %0d want %0d", c, cnt[c], want[c]);
      end
    end
    cmp++;
    if (cnt[0] < N * 24576 / 96000 - 1 || cnt[0] > N * 24576 / 96000 + 1) begin
      errs++;
      $display("FAIL audio_rate: got %0d want %0d +-1", cnt[0], N * 24576 / 96000);
    end
  endtask

  task automatic test_random();
    int drop;
    drop = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clkin);
      cmp++;
      if (ce !== m_ce || ready !== m_ready) begin
        errs++;
        $display("FAIL random cyc %0d: ce=%b ready=%b want ce=%b ready=%b", i, ce, ready, m_ce, m_ready);
      end
      sync_pulse = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      inc_wr = ($urandom_range(0, 19) == 0);
      inc_ch = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: inc_data = 32'h0;
        1: inc_data = 32'hFFFFFFFF;
        default: inc_data = $urandom;
      endcase
      if (drop > 0) begin
        drop--;
        pll_lock = (drop == 0);
      end else if ($urandom_range(0, 499) == 0) begin
        drop = $urandom_range(1, 3);
        pll_lock = 1'b0;
      end
    end
    sync_pulse = 1'b0;
    inc_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pll_lock = 1'b0; enable = 1'b0; sync_pulse = 1'b0;
    inc_wr = 1'b0; inc_ch = 2'd0; inc_data = 32'h0;
    test_reset();
    test_lock_qualify();
    test_lock_glitch();
    test_exact_rate();
    test_runtime_write();
    test_sync();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", cmp);
    $fatal(1, "watchdog");
  end

endmodule
